// File: rtl/fpga_spi_cmd_rx_if.sv
// SPI pin bundle plus the decoded configuration outputs of the command receiver.
interface fpga_spi_cmd_rx_if;
    logic       spck;
    logic       mosi;
    logic       ncs;
    logic       miso;
    logic [7:0] conf_word;
    logic       trace_enable;
    logic       cmd_strobe;
    logic       frame_err;

    modport slave (
        input  spck, mosi, ncs,
        output miso, conf_word, trace_enable, cmd_strobe, frame_err
    );

    modport master (
        output spck, mosi, ncs,
        input  miso, conf_word, trace_enable, cmd_strobe, frame_err
    );
endinterface

// File: rtl/fpga_spi_cmd_rx.sv
// Oversampled SPI command receiver: assembles WORD_BITS command words in the
// ck_1356meg domain, applies them once per frame and streams the config back on miso.
module fpga_spi_cmd_rx #(
    parameter int         SYNC_STAGES = 2,   // minimum 2
    parameter int         WORD_BITS   = 16,
    parameter logic [7:0] CONF_RESET  = 8'hE0
) (
    input  logic             ck_1356meg,
    input  logic             nrst,
    fpga_spi_cmd_rx_if.slave spi
);
    localparam int CNT_W = $clog2(WORD_BITS + 2);
    localparam int SET_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_BITS + 1);
    localparam logic [SET_W-1:0] SETTLED  = SET_W'(SYNC_STAGES + 1);
    localparam logic [2:0]       PIN_IDLE = 3'b100; // {ncs, mosi, spck}

    // SYNC/DRAIN exist only after reset: a frame already in flight when nrst
    // releases is swallowed up to its closing ncs edge without side effects.
    typedef enum logic [2:0] {
        ST_SYNC, ST_DRAIN, ST_IDLE, ST_SHIFT, ST_CLOSE
    } state_t;

    logic [SYNC_STAGES-1:0][2:0] sync_pipe;
    logic [1:0]                  edge_q;     // previous {ncs, spck}
    logic                        ncs_s, mosi_s, spck_s;
    logic                        spck_rise, spck_fall, ncs_rise, ncs_fall;

    state_t                 state, state_nxt;
    logic [SET_W-1:0]       settle, settle_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [WORD_BITS-1:0]   shift_reg, shift_nxt;
    logic [WORD_BITS-1:0]   rb, rb_nxt, rb_load;
    logic                   miso_q, miso_nxt;
    logic [7:0]             conf_q, conf_nxt;
    logic                   trace_q, trace_nxt;
    logic                   strobe_q, strobe_nxt;
    logic                   err_q, err_nxt;

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            sync_pipe <= {SYNC_STAGES{PIN_IDLE}};
            edge_q    <= 2'b10;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], {spi.ncs, spi.mosi, spi.spck}};
            edge_q    <= {sync_pipe[SYNC_STAGES-1][2], sync_pipe[SYNC_STAGES-1][0]};
        end
    end

    assign ncs_s     = sync_pipe[SYNC_STAGES-1][2];
    assign mosi_s    = sync_pipe[SYNC_STAGES-1][1];
    assign spck_s    = sync_pipe[SYNC_STAGES-1][0];
    assign spck_rise =  spck_s & ~edge_q[0];
    assign spck_fall = ~spck_s &  edge_q[0];
    assign ncs_rise  =  ncs_s  & ~edge_q[1];
    assign ncs_fall  = ~ncs_s  &  edge_q[1];
    assign rb_load   = WORD_BITS'({trace_q, conf_q});

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_SYNC;
            settle    <= '0;
            cnt       <= '0;
            shift_reg <= '0;
            rb        <= '0;
            miso_q    <= 1'b0;
            conf_q    <= CONF_RESET;
            trace_q   <= 1'b0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            settle    <= settle_nxt;
            cnt       <= cnt_nxt;
            shift_reg <= shift_nxt;
            rb        <= rb_nxt;
            miso_q    <= miso_nxt;
            conf_q    <= conf_nxt;
            trace_q   <= trace_nxt;
            strobe_q  <= strobe_nxt;
            err_q     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle;
        cnt_nxt    = cnt;
        shift_nxt  = shift_reg;
        rb_nxt     = rb;
        miso_nxt   = miso_q;
        conf_nxt   = conf_q;
        trace_nxt  = trace_q;
        strobe_nxt = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            // A fall seen before the pipeline has filled is a frame that began under reset.
            ST_SYNC: begin
                if (settle != SETTLED) settle_nxt = settle + 1'b1;
                if (ncs_fall)                state_nxt = ST_DRAIN;
                else if (settle == SETTLED)  state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                miso_nxt = 1'b0;
                if (ncs_rise) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                miso_nxt = 1'b0;
                if (ncs_fall) begin
                    cnt_nxt   = '0;
                    rb_nxt    = rb_load;
                    miso_nxt  = rb_load[WORD_BITS-1];
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (spck_rise) begin
                    shift_nxt = {shift_reg[WORD_BITS-2:0], mosi_s};
                    if (cnt != CNT_SAT) cnt_nxt = cnt + 1'b1;
                end
                if (spck_fall) begin
                    rb_nxt   = rb << 1;
                    miso_nxt = rb[WORD_BITS-2];
                end
                if (ncs_rise) state_nxt = ST_CLOSE;
            end
            ST_CLOSE: begin
                miso_nxt  = 1'b0;
                state_nxt = ST_IDLE;
                if (cnt == CNT_FULL) begin
                    case (shift_reg[WORD_BITS-1 -: 4])
                        4'b0001: begin conf_nxt  = shift_reg[7:0]; strobe_nxt = 1'b1; end
                        4'b0010: begin trace_nxt = shift_reg[0];   strobe_nxt = 1'b1; end
                        4'b0011: strobe_nxt = 1'b1;
                        default: ;
                    endcase
                end else begin
                    err_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign spi.miso         = miso_q;
    assign spi.conf_word    = conf_q;
    assign spi.trace_enable = trace_q;
    assign spi.cmd_strobe   = strobe_q;
    assign spi.frame_err    = err_q;
endmodule

// File: doc/fpga_spi_cmd_rx.md
Name: fpga_spi_cmd_rx

Overview:
Synchronous replacement for the ARM-to-FPGA SPI command receiver in the HF top level. It oversamples spck/mosi/ncs in the 13.56 MHz domain and assembles 16-bit command words. It decodes the command words into the configuration byte (major mode plus mode bits) and the trace-enable bit consumed by the mode muxes and trace capture. It also returns a status word on miso so the ARM can read the active configuration back.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each of spck, mosi and ncs before edge detection (minimum 2).
WORD_BITS, 16, SPI command word length; the opcode is always bits [WORD_BITS-1:WORD_BITS-4].
CONF_RESET, 8'hE0, conf_word value after reset (major mode 111, everything off).

Ports:
ck_1356meg  input  1  sole clock; all logic on its rising edge.
nrst  input  1  asynchronous active-low reset.
spck  input  1  SPI clock from ARM, asynchronous; max frequency ck_1356meg/8.
mosi  input  1  SPI data from ARM, sampled on spck rising edge.
ncs  input  1  SPI chip select, active low, asynchronous.
miso  output  1  SPI readback data, changes after spck falling edge.
conf_word  output  8  configuration register; [7:5] is the major mode.
trace_enable  output  1  trace capture enable.
cmd_strobe  output  1  one-cycle pulse when a valid command has been applied.
frame_err  output  1  one-cycle pulse when a frame closes with a bit count other than WORD_BITS.

Behaviour:
- Reset (nrst low, asynchronous): conf_word=CONF_RESET, trace_enable=0, cmd_strobe=0, frame_err=0, miso=0, bit counter=0, shift register=0, all synchronizer stages cleared to idle (spck=0, ncs=1). Deasserting nrst in the middle of a frame discards that frame: the receiver waits for an ncs rising edge, and that edge produces no strobe and no error.
- Synchronization: each input passes through SYNC_STAGES FFs. One further FF holds the previous value for edge detection. Edges are single-cycle events.
- States: IDLE (ncs high), SHIFT (ncs low), CLOSE (one cycle after the ncs rising edge).
- IDLE -> SHIFT on an ncs falling edge:
  - Clear the bit counter.
  - Load the readback register with {4'b0000, 3'b000, trace_enable, conf_word}.
  - Drive miso with its MSB.
- SHIFT, spck rising edge:
  - shift_reg <= {shift_reg[WORD_BITS-2:0], mosi_sync}.
  - The bit counter increments and saturates at WORD_BITS+1, so overlong frames are detectable.
- SHIFT, spck falling edge: the readback register shifts left with zero fill, and miso takes the new MSB.
- SHIFT, simultaneous ncs rising edge and spck rising edge in the same cycle: the spck edge is processed first (the bit counts), then the frame closes.
- SHIFT -> CLOSE on an ncs rising edge. In CLOSE:
  - If count==WORD_BITS, decode the opcode:
    - 0001: conf_word <= shift_reg[7:0].
    - 0010: trace_enable <= shift_reg[0].
    - 0011: no register change (readback-only frame).
    - Any other opcode: ignored, and no strobe.
    - Pulse cmd_strobe on opcodes 0001, 0010 and 0011.
  - If count!=WORD_BITS (including 0): pulse frame_err and leave the registers unchanged.
  - CLOSE -> IDLE unconditionally; miso=0.
- Register updates occur only in CLOSE. conf_word therefore changes atomically, once per frame, synchronous to ck_1356meg. This keeps mode muxes glitch-free.
- Latency:
  - An ncs rising edge at the pin updates conf_word after SYNC_STAGES+2 clocks.
  - cmd_strobe is asserted in the same cycle that conf_word first shows the new value.
- Back-to-back frames: ncs high for ≥ SYNC_STAGES+2 clocks is required between frames. A shorter gap is not guaranteed to be seen.
- Bits clocked while ncs is high are ignored.

Test Plan:
- Reset -> conf_word=8'hE0, trace_enable=0, miso=0, no strobes; assert nrst mid-operation -> outputs return to reset values immediately, without a clock edge.
- Send 16'h1021 with spck at ck/8 -> conf_word=8'h21 exactly SYNC_STAGES+2 clocks after the ncs rise, cmd_strobe high one cycle, frame_err=0.
- Send 16'h2001 then 16'h2000 -> trace_enable goes 1, then 0; conf_word is unchanged across both frames.
- Send a 15-bit frame, then a 17-bit frame, each carrying opcode 0001 and data 8'h45 -> frame_err pulses twice, conf_word remains at its prior value, cmd_strobe is never asserted.
- After conf_word=8'h21 and trace_enable=1, send 16'h3000 -> miso stream = 16'h0121 MSB first, cmd_strobe pulses, registers unchanged.
- Send opcode 0111 (16'h70FF), and separately drop nrst during bit 8 of a 16'h1055 frame and release it before ncs rises -> neither frame changes conf_word, cmd_strobe=0, frame_err=0.
